// File: rtl/traffic_input_cond.sv
// Board input conditioning for the traffic-light controller: switch synchronisers,
// per-button debounce with press pulses and sticky requests. Optional long-press via TRAFFIC_INPUT_LONGPRESS_EN.
module traffic_input_cond #(
    parameter int N_BTN     = 4,
    parameter int N_SW      = 8,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20,
    parameter int LP_CYCLES = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_SW-1:0]  sw_sync,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] req_pend,
    input  logic [N_BTN-1:0] req_clr,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {IDLE0, CHK1, IDLE1, CHK0} db_state_t;

    // Acceptance happens on the DB_CYCLES-th consecutive sample; cnt=1 after the first.
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(DB_CYCLES - 1);

    logic [N_SW-1:0]  sw_meta;
    logic [N_BTN-1:0] btn_meta;
    logic [N_BTN-1:0] btn_sync;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // A pulse and a clear landing together leave the request set.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) req_pend <= '0;
        else       req_pend <= btn_pulse | (req_pend & ~req_clr);
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        db_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             pulse;

        always_ff @(posedge clk or posedge Reset) begin
            if (Reset) begin
                state <= IDLE0;
                cnt   <= '0;
                level <= 1'b0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                case (state)
                    IDLE0: if (btn_sync[i]) begin
                        state <= CHK1;
                        cnt   <= CNT_W'(1);
                    end
                    CHK1: if (!btn_sync[i]) begin
                        state <= IDLE0;
                        cnt   <= '0;
                    end else if (cnt == ACCEPT_CNT) begin
                        state <= IDLE1;
                        cnt   <= '0;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    IDLE1: if (!btn_sync[i]) begin
                        state <= CHK0;
                        cnt   <= CNT_W'(1);
                    end
                    CHK0: if (btn_sync[i]) begin
                        state <= IDLE1;
                        cnt   <= '0;
                    end else if (cnt == ACCEPT_CNT) begin
                        state <= IDLE0;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    default: begin
                        state <= IDLE0;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i] = level;
        assign btn_pulse[i] = pulse;

`ifdef TRAFFIC_INPUT_LONGPRESS_EN
        localparam int HOLD_W = $clog2(LP_CYCLES + 1);
        logic [HOLD_W-1:0] hold;
        logic              long_q;

        // Hold counter only advances while settled pressed; saturation gives one pulse per press.
        always_ff @(posedge clk or posedge Reset) begin
            if (Reset) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (state == IDLE1 && btn_sync[i]) begin
                    if (hold != HOLD_W'(LP_CYCLES)) hold <= hold + HOLD_W'(1);
                    if (hold == HOLD_W'(LP_CYCLES - 1)) long_q <= 1'b1;
                end else begin
                    hold <= '0;
                end
            end
        end

        assign btn_long[i] = long_q;
`else
        // LP_CYCLES has no effect in this build; the expression is constant 0.
        assign btn_long[i] = (LP_CYCLES < 0);
`endif
    end

endmodule

// File: tb/tb_traffic_input_cond.sv
// Self-checking bench for traffic_input_cond: directed steps plus randomized input
// segments, checked every cycle against a run-length reference model.
module tb_traffic_input_cond;

    localparam int NB = 4;
    localparam int NS = 8;
    localparam int DB = 8;
    localparam int LP = 20;
`ifdef TRAFFIC_INPUT_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          Reset;
    logic [NB-1:0] btn_raw, req_clr;
    logic [NS-1:0] sw_raw;
    logic [NS-1:0] sw_sync;
    logic [NB-1:0] btn_level, btn_pulse, req_pend, btn_long;

    traffic_input_cond #(
        .N_BTN(NB), .N_SW(NS), .DB_CYCLES(DB), .CNT_W(4), .LP_CYCLES(LP)
    ) dut (
        .clk(clk), .Reset(Reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .sw_sync(sw_sync), .btn_level(btn_level), .btn_pulse(btn_pulse),
        .req_pend(req_pend), .req_clr(req_clr), .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: two-stage delay lines, then per button a count of consecutive
    // samples disagreeing with the accepted level; DB of them flip the level.
    logic [NS-1:0] m_sw1, m_sw2;
    logic [NB-1:0] m_b1, m_b2;
    logic [NB-1:0] e_level, e_pulse, e_req, e_long;
    int            run [NB];
    int            held[NB];

    task automatic model_step();
        logic [NB-1:0] s;
        bit            settled_hold;
        if (Reset) begin
            m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
            e_level = '0; e_pulse = '0; e_req = '0; e_long = '0;
            for (int i = 0; i < NB; i++) begin run[i] = 0; held[i] = 0; end
            return;
        end
        s     = m_b2;
        m_sw2 = m_sw1;  m_sw1 = sw_raw;
        m_b2  = m_b1;   m_b1  = btn_raw;
        e_req   = e_pulse | (e_req & ~req_clr);
        e_pulse = '0;
        e_long  = '0;
        for (int i = 0; i < NB; i++) begin
            settled_hold = e_level[i] && run[i] == 0 && s[i];
            if (s[i] != e_level[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    e_level[i] = s[i];
                    e_pulse[i] = s[i];
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
            if (settled_hold) begin
                if (held[i] < LP) begin
                    held[i]++;
                    if (held[i] == LP && LP_EN) e_long[i] = 1'b1;
                end
            end else begin
                held[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sw_sync",   32'(sw_sync),   32'(m_sw2));
        chk("btn_level", 32'(btn_level), 32'(e_level));
        chk("btn_pulse", 32'(btn_pulse), 32'(e_pulse));
        chk("req_pend",  32'(req_pend),  32'(e_req));
        chk("btn_long",  32'(btn_long),  32'(e_long));
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    int n_long;
    int long_at;

    initial begin
        // 1: reset with everything driven high
        Reset = 1'b1; btn_raw = 4'hF; sw_raw = 8'hA5; req_clr = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rst_outputs", 32'({sw_sync, btn_level, btn_pulse, req_pend, btn_long}), 32'd0);
        end
        Reset = 1'b0;
        cycle();
        cycle();
        chk("sw_after_rst", 32'(sw_sync), 32'hA5);
        btn_raw = '0;
        cycles(12);
        chk("short_hold_ignored", 32'(btn_level), 32'd0);

        // 2: press and release button 0
        btn_raw = 4'b0001;
        cycles(9);
        chk("b0_pre_edge10", 32'({btn_level[0], btn_pulse[0]}), 32'd0);
        cycle();
        chk("b0_edge10", 32'({btn_level[0], btn_pulse[0]}), 32'b11);
        cycle();
        chk("b0_pulse_once", 32'({btn_level[0], btn_pulse[0], req_pend[0]}), 32'b101);
        btn_raw = '0;
        cycles(9);
        chk("b0_rel_pre", 32'(btn_level[0]), 32'd1);
        cycle();
        chk("b0_rel_edge10", 32'({btn_level[0], btn_pulse[0]}), 32'd0);

        // 3: bounce shorter than the debounce window
        btn_raw = 4'b0010;
        cycles(5);
        btn_raw = '0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("b1_bounce", 32'({btn_level[1], btn_pulse[1], req_pend[1]}), 32'd0);
        end

        // 4: clear alone, then clear colliding with a new pulse
        req_clr = 4'b0001;
        cycle();
        chk("clr_alone", 32'(req_pend[0]), 32'd0);
        req_clr = '0;
        btn_raw = 4'b0001;
        cycles(10);
        chk("b0_repulse", 32'(btn_pulse[0]), 32'd1);
        req_clr = 4'b0001;
        cycle();
        chk("set_wins", 32'(req_pend[0]), 32'd1);
        cycle();
        chk("clr_next", 32'(req_pend[0]), 32'd0);
        req_clr = '0;
        btn_raw = '0;
        cycles(12);

        // 5: simultaneous presses
        btn_raw = 4'b1010;
        cycles(9);
        chk("multi_pre", 32'(btn_pulse), 32'd0);
        cycle();
        chk("multi_pulse", 32'(btn_pulse), 32'b1010);
        cycles(8);
        btn_raw = '0;
        cycles(12);

        // 6: long hold on button 2
        btn_raw = 4'b0100;
        n_long = 0;
        long_at = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (btn_long[2]) begin n_long++; long_at = k; end
        end
        chk("long_count", 32'(n_long), LP_EN ? 32'd1 : 32'd0);
        chk("long_timing", 32'(long_at), LP_EN ? 32'(DB + 2 + LP) : 32'hFFFF_FFFF);
        btn_raw = '0;
        cycles(12);

        // Reset mid-debounce while held: full requalification afterwards
        btn_raw = 4'b0001;
        cycles(5);
        Reset = 1'b1;
        cycles(2);
        Reset = 1'b0;
        cycles(9);
        chk("rst_abort_pre", 32'(btn_level[0]), 32'd0);
        cycle();
        chk("rst_abort_accept", 32'(btn_pulse[0]), 32'd1);
        btn_raw = '0;
        cycles(12);

        // Randomized segments checked cycle by cycle against the model
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            btn_raw = 4'($urandom_range(0, 15));
            sw_raw  = 8'($urandom);
            len     = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                req_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
                cycle();
            end
        end
        req_clr = '0;
        btn_raw = 4'b0100;
        cycles(DB + LP + 6);
        btn_raw = '0;
        cycles(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
